// File: rtl/spi_clgen_mode_pkg.sv
// rtl/spi_clgen_mode_pkg.sv - shared defaults, mode encodings and strobe decode for the SPI clock generator
package spi_clgen_mode_pkg;

    localparam int SPI_DIVIDER_LEN   = 16;
    localparam int SPI_CHAR_LEN_BITS = 7;

    // Mode numbers are {cpol, cpha}.
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } clg_state_t;

    typedef struct packed {
        logic drive;
        logic sample;
    } strobe_t;

    // Which shifter strobes accompany an sclk edge. With cpha=0 the first bit is
    // presented at accept time, so the final trailing edge carries no drive.
    function automatic strobe_t edge_strobes(input logic cpha,
                                             input logic leading,
                                             input logic final_edge);
        strobe_t s;
        s = '0;
        if (cpha) begin
            s.drive  = leading;
            s.sample = !leading;
        end else begin
            s.sample = leading;
            s.drive  = !leading && !final_edge;
        end
        return s;
    endfunction

endpackage

// File: rtl/spi_clk_prescaler.sv
// rtl/spi_clk_prescaler.sv - reloadable down-counter producing one tick per sclk half-period
module spi_clk_prescaler
#(
    parameter int DIV_LEN = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [DIV_LEN-1:0] divider,
    output logic               edge_tick
);

    localparam logic [DIV_LEN-1:0] CNT_ONE = DIV_LEN'(1);

    logic [DIV_LEN-1:0] cnt;
    logic [DIV_LEN-1:0] div_q;

    // A tick is the cycle in which the half-period expires.
    assign edge_tick = run && (cnt == '0);

    // Hold the reload value taken at accept so later divider writes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (load) begin
            div_q <= divider;
        end
    end

    // Count down each cycle while running; reload on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= divider;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= div_q;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/spi_clgen_mode.sv
// rtl/spi_clgen_mode.sv - four-mode SPI serial clock generator with transfer control and shifter strobes
module spi_clgen_mode
    import spi_clgen_mode_pkg::*;
#(
    parameter int DIV_LEN = SPI_DIVIDER_LEN,
    parameter int LEN_W   = SPI_CHAR_LEN_BITS
) (
    input  logic               wb_clk_in,
    input  logic               wb_rst_n,
    input  logic               go,
    input  logic [DIV_LEN-1:0] divider,
    input  logic [LEN_W-1:0]   char_len,
    input  logic               cpol,
    input  logic               cpha,
    output logic               sclk_out,
    output logic               tip,
    output logic               last_clk,
    output logic               drive_stb,
    output logic               sample_stb,
    output logic               done
);

    // Edge numbers run to 2*2**LEN_W, one bit wider than the edge counter.
    localparam int EW = LEN_W + 2;
    localparam logic [EW-1:0] EDGE_ONE = EW'(1);

    clg_state_t       state;
    clg_state_t       state_next;
    logic [LEN_W:0]   edge_cnt;
    logic [LEN_W-1:0] len_q;
    logic             cpol_q;
    logic             cpha_q;
    logic             sclk_q;
    logic             last_q;
    logic             drive_q;
    logic             sample_q;
    logic             done_q;

    logic             edge_tick;
    logic             accept;
    logic             final_edge;
    logic             penult_edge;
    logic             leading;
    logic [EW-1:0]    edge_num;
    logic [EW-1:0]    total_edges;
    logic [EW-1:0]    total_m1;
    strobe_t          stb;

    spi_clk_prescaler #(
        .DIV_LEN (DIV_LEN)
    ) u_prescaler (
        .clk       (wb_clk_in),
        .rst_n     (wb_rst_n),
        .load      (accept),
        .run       (tip),
        .divider   (divider),
        .edge_tick (edge_tick)
    );

    assign tip        = (state == ST_RUN);
    assign sclk_out   = sclk_q;
    assign last_clk   = last_q;
    assign drive_stb  = drive_q;
    assign sample_stb = sample_q;
    assign done       = done_q;

    // char_len==0 encodes the full 2**LEN_W bits via the extra top bit.
    assign total_edges = {(len_q == '0), len_q, 1'b0};
    assign total_m1    = total_edges - EDGE_ONE;
    assign edge_num    = {1'b0, edge_cnt} + EDGE_ONE;
    assign leading     = ~edge_cnt[0];

    // Next state, accept decision and per-edge classification.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        final_edge  = 1'b0;
        penult_edge = 1'b0;
        stb         = '0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (edge_tick) begin
                    final_edge  = (edge_num == total_edges);
                    penult_edge = (edge_num == total_m1);
                    stb         = edge_strobes(cpha_q, leading, final_edge);
                    if (final_edge) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Transfer state register.
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Freeze the transfer configuration at accept.
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            len_q  <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (accept) begin
            len_q  <= char_len;
            cpol_q <= cpol;
            cpha_q <= cpha;
        end
    end

    // Registered strobes; cpha=0 presents the first bit right after accept.
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            drive_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            drive_q  <= stb.drive | (accept & ~cpha);
            sample_q <= stb.sample;
            done_q   <= final_edge;
        end
    end

    // sclk level, edge counter and last-half-period flag.
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sclk_q   <= 1'b0;
            edge_cnt <= '0;
            last_q   <= 1'b0;
        end else if (state == ST_IDLE) begin
            sclk_q   <= cpol;
            edge_cnt <= '0;
            last_q   <= 1'b0;
        end else if (edge_tick) begin
            edge_cnt <= edge_num[LEN_W:0];
            sclk_q   <= final_edge ? cpol_q : ~sclk_q;
            last_q   <= penult_edge;
        end
    end

endmodule

// File: tb/tb_spi_clgen_mode.sv
// tb/tb_spi_clgen_mode.sv - randomized self-checking bench for spi_clgen_mode
module tb_spi_clgen_mode;

    logic        wb_clk_in = 1'b0;
    logic        wb_rst_n;
    logic        go;
    logic [15:0] divider;
    logic [6:0]  char_len;
    logic        cpol;
    logic        cpha;
    logic        sclk_out;
    logic        tip;
    logic        last_clk;
    logic        drive_stb;
    logic        sample_stb;
    logic        done;

    int total = 0;
    int bad   = 0;

    spi_clgen_mode #(
        .DIV_LEN (16),
        .LEN_W   (7)
    ) dut (
        .wb_clk_in  (wb_clk_in),
        .wb_rst_n   (wb_rst_n),
        .go         (go),
        .divider    (divider),
        .char_len   (char_len),
        .cpol       (cpol),
        .cpha       (cpha),
        .sclk_out   (sclk_out),
        .tip        (tip),
        .last_clk   (last_clk),
        .drive_stb  (drive_stb),
        .sample_stb (sample_stb),
        .done       (done)
    );

    always #5 wb_clk_in = ~wb_clk_in;

    // One transfer against the timing rules: edge j sits j*(d+1) cycles after accept.
    // Called just after a negedge; the next posedge is the accept edge.
    task automatic run_xfer(input int d, input int cl, input bit pol, input bit pha,
                            input bit hold, input bit mutate, input string tag);
        int L;
        int T;
        int j;
        int ndrv;
        int nsmp;
        int rv;
        bit on_edge;
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        logic [2:0] exp_i;
        logic [2:0] obs_i;
        L = (cl == 0) ? 128 : cl;
        T = 2 * L * (d + 1);
        divider  = d[15:0];
        char_len = cl[6:0];
        cpol     = pol;
        cpha     = pha;
        go       = 1'b1;
        ndrv = 0;
        nsmp = 0;
        for (int t = 0; t <= T; t++) begin
            @(negedge wb_clk_in);
            j       = t / (d + 1);
            on_edge = (t > 0) && (t % (d + 1) == 0);
            exp_v[5] = (t < T) ? (pol ^ j[0]) : pol;
            exp_v[4] = (t < T);
            exp_v[3] = (j == 2 * L - 1);
            exp_v[2] = pha ? (on_edge && j[0])
                           : ((t == 0) || (on_edge && !j[0] && (j < 2 * L)));
            exp_v[1] = on_edge && (pha ? !j[0] : j[0]);
            exp_v[0] = (t == T);
            obs_v = {sclk_out, tip, last_clk, drive_stb, sample_stb, done};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL %s t=%0d sclk/tip/last/drv/smp/done got=%b want=%b", tag, t, obs_v, exp_v);
            end
            if (drive_stb === 1'b1) ndrv++;
            if (sample_stb === 1'b1) nsmp++;
            if (t == 0) go = hold;
            if (mutate) begin
                if (t < T - 1) begin
                    rv       = $urandom;
                    go       = rv[0];
                    divider  = rv[23:8];
                    char_len = rv[30:24];
                    cpha     = rv[1];
                end else if (t == T - 1) begin
                    go = 1'b1;
                end else begin
                    go = hold;
                end
            end
        end
        total++;
        if (ndrv != L) begin
            bad++;
            $display("FAIL %s drive_count got=%0d want=%0d", tag, ndrv, L);
        end
        total++;
        if (nsmp != L) begin
            bad++;
            $display("FAIL %s sample_count got=%0d want=%0d", tag, nsmp, L);
        end
        if (!hold) begin
            @(negedge wb_clk_in);
            exp_i = {1'b0, 1'b0, pol};
            obs_i = {tip, done, sclk_out};
            total++;
            if (obs_i !== exp_i) begin
                bad++;
                $display("FAIL %s idle_after tip/done/sclk got=%b want=%b", tag, obs_i, exp_i);
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] obs_v;
        #3;
        obs_v = {sclk_out, tip, last_clk, drive_stb, sample_stb, done};
        total++;
        if (obs_v !== 6'b0) begin
            bad++;
            $display("FAIL reset_por outputs got=%b want=%b", obs_v, 6'b0);
        end
        @(negedge wb_clk_in);
        wb_rst_n = 1'b1;
        divider  = 16'd3;
        char_len = 7'd8;
        cpol     = 1'b0;
        cpha     = 1'b0;
        go       = 1'b1;
        @(negedge wb_clk_in);
        go = 1'b0;
        repeat (6) @(negedge wb_clk_in);
        total++;
        if ({tip, sclk_out} !== 2'b11) begin
            bad++;
            $display("FAIL reset_pre tip/sclk got=%b want=%b", {tip, sclk_out}, 2'b11);
        end
        #2;
        wb_rst_n = 1'b0;
        #1;
        obs_v = {sclk_out, tip, last_clk, drive_stb, sample_stb, done};
        total++;
        if (obs_v !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid outputs got=%b want=%b", obs_v, 6'b0);
        end
        @(negedge wb_clk_in);
        wb_rst_n = 1'b1;
        repeat (3) begin
            @(negedge wb_clk_in);
            total++;
            if ({sclk_out, tip, done} !== 3'b000) begin
                bad++;
                $display("FAIL reset_after sclk/tip/done got=%b want=%b", {sclk_out, tip, done}, 3'b000);
            end
        end
    endtask

    task automatic test_cpol_idle();
        cpol = 1'b1;
        #1;
        total++;
        if (sclk_out !== 1'b0) begin
            bad++;
            $display("FAIL cpol_early sclk got=%b want=%b", sclk_out, 1'b0);
        end
        @(negedge wb_clk_in);
        total++;
        if (sclk_out !== 1'b1) begin
            bad++;
            $display("FAIL cpol_follow1 sclk got=%b want=%b", sclk_out, 1'b1);
        end
        cpol = 1'b0;
        @(negedge wb_clk_in);
        total++;
        if (sclk_out !== 1'b0) begin
            bad++;
            $display("FAIL cpol_follow0 sclk got=%b want=%b", sclk_out, 1'b0);
        end
    endtask

    task automatic test_random_modes();
        int d;
        int cl;
        bit pol;
        bit pha;
        for (int i = 0; i < 8; i++) begin
            d   = $urandom_range(0, 4);
            cl  = $urandom_range(1, 12);
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            run_xfer(d, cl, pol, pha, 1'b0, 1'b1, "rand");
        end
    endtask

    task automatic test_back_to_back();
        run_xfer(2, 2, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_0");
        run_xfer(2, 2, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_1");
        run_xfer(2, 2, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_2");
    endtask

    initial begin
        wb_rst_n = 1'b0;
        go       = 1'b0;
        divider  = '0;
        char_len = '0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        test_reset();
        test_cpol_idle();
        run_xfer(1, 8, 1'b0, 1'b0, 1'b0, 1'b0, "mode0_d1_l8");
        run_xfer(0, 4, 1'b1, 1'b1, 1'b0, 1'b0, "mode3_d0_l4");
        run_xfer(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "len0_d0");
        test_back_to_back();
        test_random_modes();
        run_xfer(3, 5, 1'b1, 1'b0, 1'b0, 1'b1, "mode2_mut");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
